// File: rtl/color_event_filter.sv
// Debounces the detector's colour flags: a colour locks after STABLE_CYCLES identical
// samples, emits one valid/ready event per lock and bumps a saturating per-colour count.
module color_event_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 red_detected,
  input  logic                 green_detected,
  input  logic                 blue_detected,
  input  logic                 clear_counts,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [1:0]           evt_color,
  output logic [1:0]           current_color,
  output logic [CNT_WIDTH-1:0] red_count,
  output logic [CNT_WIDTH-1:0] green_count,
  output logic [CNT_WIDTH-1:0] blue_count,
  output logic                 evt_overrun
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] QUALIFY  = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;
  localparam logic [8:0] LOCK_RUN = 9'(STABLE_CYCLES);

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_RED   = 2'b01;
  localparam logic [1:0] C_GREEN = 2'b10;
  localparam logic [1:0] C_BLUE  = 2'b11;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A clear and an increment on the same edge leave the counter at 1.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] v,
                                                    input logic clr, input logic inc);
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : v;
    return inc ? sat_inc(base) : base;
  endfunction

  logic [1:0] code;
  logic [1:0] state, state_nx;
  logic [1:0] cand, cand_nx;
  logic [7:0] run, run_nx;
  logic       lock;
  logic       slot_free;

  // Multi-flag samples are ambiguous and count as no colour.
  always_comb begin
    code = C_NONE;
    unique case ({red_detected, green_detected, blue_detected})
      3'b100:  code = C_RED;
      3'b010:  code = C_GREEN;
      3'b001:  code = C_BLUE;
      default: code = C_NONE;
    endcase
  end

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    run_nx   = run;
    lock     = 1'b0;
    case (state)
      IDLE: begin
        if (code != C_NONE) begin
          cand_nx  = code;
          run_nx   = 8'd1;
          state_nx = QUALIFY;
        end
      end
      QUALIFY: begin
        if (code == C_NONE) begin
          state_nx = IDLE;
        end else if (code == cand) begin
          if ({1'b0, run} + 9'd1 == LOCK_RUN) begin
            state_nx = LOCKED;
            lock     = 1'b1;
          end else begin
            run_nx = run + 8'd1;
          end
        end else begin
          cand_nx = code;
          run_nx  = 8'd1;
        end
      end
      LOCKED: begin
        if (code == C_NONE) begin
          state_nx = IDLE;
        end else if (code != cand) begin
          cand_nx  = code;
          run_nx   = 8'd1;
          state_nx = QUALIFY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign slot_free = !evt_valid || evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cand          <= C_NONE;
      run           <= 8'd0;
      current_color <= C_NONE;
      evt_valid     <= 1'b0;
      evt_color     <= C_NONE;
      evt_overrun   <= 1'b0;
      red_count     <= '0;
      green_count   <= '0;
      blue_count    <= '0;
    end else begin
      state         <= state_nx;
      cand          <= cand_nx;
      run           <= run_nx;
      current_color <= (state_nx == LOCKED) ? cand_nx : C_NONE;

      if (lock && slot_free) begin
        evt_valid <= 1'b1;
        evt_color <= cand;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (lock && !slot_free) begin
        evt_overrun <= 1'b1;
      end else if (clear_counts) begin
        evt_overrun <= 1'b0;
      end

      red_count   <= cnt_next(red_count,   clear_counts, lock && (cand == C_RED));
      green_count <= cnt_next(green_count, clear_counts, lock && (cand == C_GREEN));
      blue_count  <= cnt_next(blue_count,  clear_counts, lock && (cand == C_BLUE));
    end
  end

endmodule

// File: tb/tb_color_event_filter.sv
// Bench for color_event_filter: directed scenarios then random flag streams, all
// checked against a streak-length model of the debounce and event slot.
module tb_color_event_filter;

  localparam int S    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          red_detected, green_detected, blue_detected;
  logic          clear_counts, evt_ready;
  logic          evt_valid, evt_overrun;
  logic [1:0]    evt_color, current_color;
  logic [CW-1:0] red_count, green_count, blue_count;

  color_event_filter #(.STABLE_CYCLES(S), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .red_detected  (red_detected),
    .green_detected(green_detected),
    .blue_detected (blue_detected),
    .clear_counts  (clear_counts),
    .evt_ready     (evt_ready),
    .evt_valid     (evt_valid),
    .evt_color     (evt_color),
    .current_color (current_color),
    .red_count     (red_count),
    .green_count   (green_count),
    .blue_count    (blue_count),
    .evt_overrun   (evt_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: length of the current run of identical nonzero colour codes.
  int m_prev, m_streak, m_cur, m_vld, m_col, m_ovr;
  int m_cnt[4];

  task automatic model_reset();
    m_prev = 0; m_streak = 0; m_cur = 0; m_vld = 0; m_col = 0; m_ovr = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic ir, ig, ib, iclr, irdy);
    int n, c;
    bit lk;
    n = int'(ir) + int'(ig) + int'(ib);
    c = (n != 1) ? 0 : (ir ? 1 : (ig ? 2 : 3));
    if (c == 0)           m_streak = 0;
    else if (c == m_prev) m_streak++;
    else                  m_streak = 1;
    m_prev = c;
    lk    = (c != 0) && (m_streak == S);
    m_cur = (c != 0 && m_streak >= S) ? c : 0;
    if (iclr) begin
      m_ovr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    if (lk) begin
      if (m_cnt[c] < CMAX) m_cnt[c]++;
      if (!m_vld || irdy) begin
        m_vld = 1; m_col = c;
      end else begin
        m_ovr = 1;
      end
    end else if (m_vld && irdy) begin
      m_vld = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".evt_valid"},     evt_valid,     m_vld);
    chk({ctx, ".evt_color"},     evt_color,     m_col);
    chk({ctx, ".current_color"}, current_color, m_cur);
    chk({ctx, ".red_count"},     red_count,     m_cnt[1]);
    chk({ctx, ".green_count"},   green_count,   m_cnt[2]);
    chk({ctx, ".blue_count"},    blue_count,    m_cnt[3]);
    chk({ctx, ".evt_overrun"},   evt_overrun,   m_ovr);
  endtask

  // Called 1 time unit after a rising edge; drives inputs for the next edge.
  task automatic step(input string ctx, input logic ir, ig, ib, iclr, irdy);
    red_detected = ir; green_detected = ig; blue_detected = ib;
    clear_counts = iclr; evt_ready = irdy;
    @(posedge clk);
    model_edge(ir, ig, ib, iclr, irdy);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [2:0] multi [4];
    logic [2:0] f;
    int kind, len;
    multi[0] = 3'b110; multi[1] = 3'b101; multi[2] = 3'b011; multi[3] = 3'b111;

    reset_n = 1'b0;
    red_detected = 0; green_detected = 0; blue_detected = 0;
    clear_counts = 0; evt_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Lock after hold, with the event left pending then accepted
    for (int i = 0; i < 6; i++) begin
      step("hold_red", 1, 0, 0, 0, 0);
      if (i == 2) chk("red_not_yet", evt_valid, 0);
      if (i == 3) begin
        chk("red_lock_vld", evt_valid, 1);
        chk("red_lock_col", evt_color, 2'b01);
        chk("red_lock_cnt", red_count, 1);
        chk("red_lock_cur", current_color, 2'b01);
      end
    end
    step("red_drop", 0, 0, 0, 0, 0);
    chk("red_release_cur", current_color, 2'b00);
    step("red_accept", 0, 0, 0, 0, 1);
    chk("red_accept_vld", evt_valid, 0);

    // Glitch rejection
    for (int i = 0; i < 3; i++) step("glitch_a", 0, 1, 0, 0, 1);
    step("glitch_gap", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("glitch_b", 0, 1, 0, 0, 1);
    chk("glitch_gcnt", green_count, 0);
    chk("glitch_cur", current_color, 2'b00);

    // Colour switch and multi-flag
    for (int i = 0; i < 4; i++) step("sw_blue", 0, 0, 1, 0, 1);
    chk("sw_blue_col", evt_color, 2'b11);
    for (int i = 0; i < 4; i++) step("sw_green", 0, 1, 0, 0, 1);
    chk("sw_green_col", evt_color, 2'b10);
    for (int i = 0; i < 4; i++) step("sw_multi", 1, 1, 0, 0, 1);
    chk("sw_multi_cur", current_color, 2'b00);
    chk("sw_multi_vld", evt_valid, 0);

    // Back-pressure, overrun, accept coincident with a new lock
    step("bp_clear", 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("bp_red", 1, 0, 0, 0, 0);
    step("bp_gap", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("bp_blue", 0, 0, 1, 0, 0);
    chk("bp_hold_col", evt_color, 2'b01);
    chk("bp_overrun", evt_overrun, 1);
    chk("bp_blue_cnt", blue_count, 1);
    step("bp_accept", 0, 0, 0, 0, 1);
    chk("bp_accept_vld", evt_valid, 0);
    step("bp_clear2", 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("b2b_green", 0, 1, 0, 0, 0);
    step("b2b_gap", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("b2b_red", 1, 0, 0, 0, 0);
    step("b2b_red_acc", 1, 0, 0, 0, 1);
    chk("b2b_vld", evt_valid, 1);
    chk("b2b_col", evt_color, 2'b01);
    chk("b2b_ovr", evt_overrun, 0);

    // Saturation and clear coincident with a lock
    step("sat_clear", 0, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) step("sat_red", 1, 0, 0, 0, 1);
      step("sat_gap", 0, 0, 0, 0, 1);
    end
    chk("sat_red_cnt", red_count, 3);
    for (int i = 0; i < 3; i++) step("clr_green", 0, 1, 0, 0, 1);
    step("clr_green_lock", 0, 1, 0, 1, 1);
    chk("clr_green_cnt", green_count, 1);
    chk("clr_red_cnt", red_count, 0);
    chk("clr_ovr", evt_overrun, 0);

    // Asynchronous reset mid-qualification with a pending event
    for (int i = 0; i < 4; i++) step("ar_red", 1, 0, 0, 0, 0);
    step("ar_gap", 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step("ar_blue", 0, 0, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("ar_vld_now", evt_valid, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("ar_fresh", 0, 0, 1, 0, 1);
      if (i == 2) chk("ar_fresh_early", evt_valid, 0);
      if (i == 3) begin
        chk("ar_fresh_vld", evt_valid, 1);
        chk("ar_fresh_col", evt_color, 2'b11);
      end
    end

    // Random segments of held patterns
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 7);
      case (kind)
        0:       f = 3'b000;
        1:       f = 3'b100;
        2:       f = 3'b010;
        3:       f = 3'b001;
        4:       f = multi[$urandom_range(0, 3)];
        default: f = 3'b100 >> $urandom_range(0, 2);
      endcase
      for (int i = 0; i < len; i++)
        step("rand", f[2], f[1], f[0], $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
